// File: rtl/kia_pkg.sv
// Shared definitions for the PS/2 keyboard FIFO: register map, STAT bit
// positions and receiver state encodings.
package kia_pkg;

   localparam logic [1:0] ADR_STAT  = 2'd0;
   localparam logic [1:0] ADR_DATA  = 2'd1;
   localparam logic [1:0] ADR_COUNT = 2'd2;
   localparam logic [1:0] ADR_CTRL  = 2'd3;

   localparam int STAT_EMPTY = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_PERR  = 2;
   localparam int STAT_FERR  = 3;
   localparam int STAT_OVF   = 4;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the PS/2 lines, shifts in one 11-bit
// frame, checks odd parity and stop bit, and aborts stalled frames.
module ps2_frame_rx
   import kia_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ps2_c_i,
   input  logic       ps2_d_i,
   output logic       byte_valid_o,
   output logic [7:0] byte_o,
   output logic       perr_pulse_o,
   output logic       ferr_pulse_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          c_meta_q, c_sync_q, c_prev_q, d_meta_q, d_sync_q;
   logic [1:0]    state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
   logic          fall;

   assign fall = c_prev_q & ~c_sync_q;

   // Idle level of both PS/2 lines is high, so the synchronisers reset to 1
   // and no spurious falling edge appears after reset release.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         c_meta_q <= 1'b1;
         c_sync_q <= 1'b1;
         c_prev_q <= 1'b1;
         d_meta_q <= 1'b1;
         d_sync_q <= 1'b1;
      end else begin
         c_meta_q <= ps2_c_i;
         c_sync_q <= c_meta_q;
         c_prev_q <= c_sync_q;
         d_meta_q <= ps2_d_i;
         d_sync_q <= d_meta_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      tmo_d     = tmo_q;
      valid_d   = 1'b0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
      if (fall) begin
         tmo_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (!d_sync_q) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            ST_DATA: begin
               shift_d   = {d_sync_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               par_d   = d_sync_q;
               state_d = ST_STOP;
            end
            default: begin
               state_d = ST_IDLE;
               if (!d_sync_q)                ferr_d  = 1'b1;
               else if (^{shift_q, par_q})   valid_d = 1'b1;
               else                          perr_d  = 1'b1;
            end
         endcase
      end else if (state_q != ST_IDLE) begin
         // The TIMEOUT_CYCLES-th consecutive cycle without an edge aborts.
         if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
            ferr_d  = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 3'd0;
         shift_q   <= 8'h00;
         par_q     <= 1'b0;
         tmo_q     <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         tmo_q     <= tmo_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
      end
   end

   assign byte_valid_o = valid_q;
   assign byte_o       = shift_q;
   assign perr_pulse_o = perr_q;
   assign ferr_pulse_o = ferr_q;

endmodule

// File: rtl/ps2_kia_fifo.sv
// PS/2 keyboard interface: frame receiver feeding a circular byte queue,
// exposed through a four-register Wishbone-style slave with level IRQ.
module ps2_kia_fifo
   import kia_pkg::*;
#(
   parameter int DEPTH_LOG2     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       CLK_I,
   input  logic       RES_I,
   input  logic       CYC_I,
   input  logic       STB_I,
   input  logic       WE_I,
   input  logic [1:0] ADR_I,
   input  logic [7:0] DAT_I,
   output logic [7:0] DAT_O,
   output logic       ACK_O,
   output logic       IRQ_O,
   input  logic       D_I,
   input  logic       C_I
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  ovf_q, ovf_d, ferr_q, ferr_d, perr_q, perr_d;
   logic                  ie_q, ie_d, ack_q, irq_q, irq_d;
   logic [7:0]            dat_q, dat_d, rdata;
   logic                  rx_valid, rx_perr, rx_ferr;
   logic [7:0]            rx_byte;
   logic                  access, w1c_en, full, empty, push, pop;

   ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk_i        (CLK_I),
      .rst_i        (RES_I),
      .ps2_c_i      (C_I),
      .ps2_d_i      (D_I),
      .byte_valid_o (rx_valid),
      .byte_o       (rx_byte),
      .perr_pulse_o (rx_perr),
      .ferr_pulse_o (rx_ferr)
   );

   // ACK_O masks the strobe for one cycle so each access has a single effect.
   assign access = CYC_I & STB_I & ~ack_q;
   assign w1c_en = access & WE_I & (ADR_I == ADR_STAT);
   assign full   = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
   assign empty  = (count_q == '0);
   assign push   = rx_valid & ~full;
   assign pop    = access & WE_I & (ADR_I == ADR_DATA) & ~empty;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;

      // A flag being set wins over a simultaneous write-1-to-clear.
      perr_d = rx_perr | (perr_q & ~(w1c_en & DAT_I[STAT_PERR]));
      ferr_d = rx_ferr | (ferr_q & ~(w1c_en & DAT_I[STAT_FERR]));
      ovf_d  = (rx_valid & full) | (ovf_q & ~(w1c_en & DAT_I[STAT_OVF]));
      ie_d   = (access && WE_I && ADR_I == ADR_CTRL) ? DAT_I[0] : ie_q;
      irq_d  = ie_d & ((count_d != '0) | perr_d | ferr_d | ovf_d);

      case (ADR_I)
         ADR_STAT:  rdata = {3'b000, ovf_q, ferr_q, perr_q, full, empty};
         ADR_DATA:  rdata = empty ? 8'h00 : mem_q[rd_ptr_q];
         ADR_COUNT: rdata = 8'(count_q);
         default:   rdata = {7'b0, ie_q};
      endcase
      dat_d = (access && !WE_I) ? rdata : dat_q;
   end

   always_ff @(posedge CLK_I) begin
      if (push) mem_q[wr_ptr_q] <= rx_byte;
   end

   always_ff @(posedge CLK_I or posedge RES_I) begin
      if (RES_I) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         ferr_q   <= 1'b0;
         perr_q   <= 1'b0;
         ie_q     <= 1'b0;
         ack_q    <= 1'b0;
         irq_q    <= 1'b0;
         dat_q    <= 8'h00;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         ferr_q   <= ferr_d;
         perr_q   <= perr_d;
         ie_q     <= ie_d;
         ack_q    <= access;
         irq_q    <= irq_d;
         dat_q    <= dat_d;
      end
   end

   assign ACK_O = ack_q;
   assign DAT_O = dat_q;
   assign IRQ_O = irq_q;

endmodule

// File: tb/tb_ps2_kia_fifo.sv
// Directed testbench for ps2_kia_fifo with a 4-entry queue and short timeout.
module tb_ps2_kia_fifo;
   import kia_pkg::*;

   localparam int TMO = 100;

   logic       CLK_I = 1'b0;
   logic       RES_I = 1'b1;
   logic       CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
   logic [1:0] ADR_I = 2'd0;
   logic [7:0] DAT_I = 8'h00;
   logic [7:0] DAT_O;
   logic       ACK_O, IRQ_O;
   logic       D_I = 1'b1, C_I = 1'b1;

   int vectors = 0;
   int miscompares = 0;

   ps2_kia_fifo #(.DEPTH_LOG2(2), .TIMEOUT_CYCLES(TMO)) dut (
      .CLK_I(CLK_I), .RES_I(RES_I), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
      .ADR_I(ADR_I), .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK_O(ACK_O), .IRQ_O(IRQ_O),
      .D_I(D_I), .C_I(C_I)
   );

   always #5 CLK_I = ~CLK_I;

   task automatic wait_clks(input int n);
      repeat (n) @(negedge CLK_I);
   endtask

   // One bus access; returns DAT_O as sampled while ACK_O is high.
   task automatic bus_access(input logic we, input logic [1:0] adr,
                             input logic [7:0] wdata, output logic [7:0] rdata);
      int n;
      @(negedge CLK_I);
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = wdata;
      n = 0;
      do begin
         @(negedge CLK_I);
         n++;
      end while (ACK_O !== 1'b1 && n < 4);
      rdata = DAT_O;
      if (ACK_O !== 1'b1) begin
         vectors++; miscompares++;
         $display("[TB] FAIL ack_timeout: ACK_O=%b required 1", ACK_O);
      end
      CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
   endtask

   // Bits go out start, data LSB first, parity, stop; D changes while C is high.
   task automatic send_bits(input logic [7:0] data, input logic par,
                            input logic stop, input int nbits);
      logic [10:0] frame;
      frame = {stop, par, data, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         D_I = frame[i];
         wait_clks(4);
         C_I = 1'b0;
         wait_clks(8);
         C_I = 1'b1;
         wait_clks(4);
      end
      D_I = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] data, input logic par);
      send_bits(data, par, 1'b1, 11);
      wait_clks(10);
   endtask

   task automatic test_reset;
      logic [7:0] r;
      wait_clks(3);
      vectors++;
      if (ACK_O !== 1'b0 || DAT_O !== 8'h00 || IRQ_O !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: ACK=%b DAT=%h IRQ=%b required 0 00 0", ACK_O, DAT_O, IRQ_O);
      end
      RES_I = 1'b0;
      wait_clks(2);
      bus_access(1'b0, ADR_STAT, 8'h00, r);
      vectors++;
      if (r !== 8'h01) begin miscompares++; $display("[TB] FAIL reset_stat: got %h required 01", r); end
      bus_access(1'b0, ADR_COUNT, 8'h00, r);
      vectors++;
      if (r !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_count: got %h required 00", r); end
      bus_access(1'b0, ADR_CTRL, 8'h00, r);
      vectors++;
      if (r !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_ctrl: got %h required 00", r); end
   endtask

   task automatic test_good_frame;
      logic [7:0] r;
      send_frame(8'h1C, 1'b0);
      bus_access(1'b0, ADR_COUNT, 8'h00, r);
      vectors++;
      if (r !== 8'h01) begin miscompares++; $display("[TB] FAIL good_count: got %h required 01", r); end
      bus_access(1'b0, ADR_STAT, 8'h00, r);
      vectors++;
      if (r !== 8'h00) begin miscompares++; $display("[TB] FAIL good_stat: got %h required 00", r); end
      bus_access(1'b0, ADR_DATA, 8'h00, r);
      vectors++;
      if (r !== 8'h1C) begin miscompares++; $display("[TB] FAIL good_data: got %h required 1c", r); end
      bus_access(1'b1, ADR_DATA, 8'hFF, r);
      bus_access(1'b0, ADR_STAT, 8'h00, r);
      vectors++;
      if (r !== 8'h01) begin miscompares++; $display("[TB] FAIL good_stat_after_pop: got %h required 01", r); end
   endtask

   task automatic test_parity_error;
      logic [7:0] r;
      send_frame(8'h1C, 1'b1);
      bus_access(1'b0, ADR_STAT, 8'h00, r);
      vectors++;
      if (r !== 8'h05) begin miscompares++; $display("[TB] FAIL perr_stat: got %h required 05", r); end
      bus_access(1'b0, ADR_COUNT, 8'h00, r);
      vectors++;
      if (r !== 8'h00) begin miscompares++; $display("[TB] FAIL perr_count: got %h required 00", r); end
      bus_access(1'b1, ADR_STAT, 8'h04, r);
      bus_access(1'b0, ADR_STAT, 8'h00, r);
      vectors++;
      if (r !== 8'h01) begin miscompares++; $display("[TB] FAIL perr_clear: got %h required 01", r); end
   endtask

   task automatic test_overflow;
      logic [7:0] r;
      logic [7:0] bytes [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      logic       pars  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) send_frame(bytes[i], pars[i]);
      bus_access(1'b0, ADR_STAT, 8'h00, r);
      vectors++;
      if (r !== 8'h12) begin miscompares++; $display("[TB] FAIL ovf_stat: got %h required 12", r); end
      bus_access(1'b0, ADR_COUNT, 8'h00, r);
      vectors++;
      if (r !== 8'h04) begin miscompares++; $display("[TB] FAIL ovf_count: got %h required 04", r); end
      for (int i = 0; i < 4; i++) begin
         bus_access(1'b0, ADR_DATA, 8'h00, r);
         vectors++;
         if (r !== bytes[i]) begin
            miscompares++;
            $display("[TB] FAIL ovf_data%0d: got %h required %h", i, r, bytes[i]);
         end
         bus_access(1'b1, ADR_DATA, 8'h00, r);
      end
      bus_access(1'b1, ADR_STAT, 8'h10, r);
      bus_access(1'b0, ADR_STAT, 8'h00, r);
      vectors++;
      if (r !== 8'h01) begin miscompares++; $display("[TB] FAIL ovf_clear: got %h required 01", r); end
   endtask

   task automatic test_timeout;
      logic [7:0] r;
      send_bits(8'hAA, 1'b1, 1'b1, 4);
      wait_clks(TMO + 10);
      bus_access(1'b0, ADR_STAT, 8'h00, r);
      vectors++;
      if (r !== 8'h09) begin miscompares++; $display("[TB] FAIL tmo_stat: got %h required 09", r); end
      bus_access(1'b1, ADR_STAT, 8'h08, r);
      send_frame(8'hAA, 1'b1);
      bus_access(1'b0, ADR_COUNT, 8'h00, r);
      vectors++;
      if (r !== 8'h01) begin miscompares++; $display("[TB] FAIL tmo_count: got %h required 01", r); end
      bus_access(1'b0, ADR_DATA, 8'h00, r);
      vectors++;
      if (r !== 8'hAA) begin miscompares++; $display("[TB] FAIL tmo_data: got %h required aa", r); end
      bus_access(1'b1, ADR_DATA, 8'h00, r);
   endtask

   task automatic test_irq;
      logic [7:0] r;
      bus_access(1'b1, ADR_CTRL, 8'h01, r);
      bus_access(1'b0, ADR_CTRL, 8'h00, r);
      vectors++;
      if (r !== 8'h01) begin miscompares++; $display("[TB] FAIL irq_ctrl: got %h required 01", r); end
      vectors++;
      if (IRQ_O !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_idle: IRQ_O=%b required 0", IRQ_O); end
      send_frame(8'h3C, 1'b1);
      vectors++;
      if (IRQ_O !== 1'b1) begin miscompares++; $display("[TB] FAIL irq_set: IRQ_O=%b required 1", IRQ_O); end
      bus_access(1'b1, ADR_DATA, 8'h00, r);
      @(negedge CLK_I);
      vectors++;
      if (IRQ_O !== 1'b0) begin miscompares++; $display("[TB] FAIL irq_clear: IRQ_O=%b required 0", IRQ_O); end
      vectors++;
      if (ACK_O !== 1'b0) begin miscompares++; $display("[TB] FAIL ack_single: ACK_O=%b required 0", ACK_O); end
      bus_access(1'b1, ADR_DATA, 8'h00, r);
      bus_access(1'b1, ADR_DATA, 8'h00, r);
      bus_access(1'b0, ADR_COUNT, 8'h00, r);
      vectors++;
      if (r !== 8'h00) begin miscompares++; $display("[TB] FAIL empty_pop_count: got %h required 00", r); end
      bus_access(1'b0, ADR_STAT, 8'h00, r);
      vectors++;
      if (r !== 8'h01) begin miscompares++; $display("[TB] FAIL empty_pop_stat: got %h required 01", r); end
   endtask

   task automatic test_reset_midframe;
      logic [7:0] r;
      send_frame(8'h1C, 1'b0);
      bus_access(1'b0, ADR_DATA, 8'h00, r);
      vectors++;
      if (IRQ_O !== 1'b1 || r !== 8'h1C) begin
         miscompares++;
         $display("[TB] FAIL pre_reset: IRQ=%b DAT=%h required 1 1c", IRQ_O, r);
      end
      send_bits(8'h55, 1'b1, 1'b1, 5);
      RES_I = 1'b1;
      #1;
      vectors++;
      if (ACK_O !== 1'b0 || DAT_O !== 8'h00 || IRQ_O !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL async_reset: ACK=%b DAT=%h IRQ=%b required 0 00 0", ACK_O, DAT_O, IRQ_O);
      end
      wait_clks(3);
      RES_I = 1'b0;
      wait_clks(2);
      bus_access(1'b0, ADR_CTRL, 8'h00, r);
      vectors++;
      if (r !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_ctrl: got %h required 00", r); end
      bus_access(1'b0, ADR_STAT, 8'h00, r);
      vectors++;
      if (r !== 8'h01) begin miscompares++; $display("[TB] FAIL rst_stat: got %h required 01", r); end
      send_frame(8'h55, 1'b1);
      bus_access(1'b0, ADR_COUNT, 8'h00, r);
      vectors++;
      if (r !== 8'h01) begin miscompares++; $display("[TB] FAIL rst_count: got %h required 01", r); end
      bus_access(1'b0, ADR_DATA, 8'h00, r);
      vectors++;
      if (r !== 8'h55) begin miscompares++; $display("[TB] FAIL rst_data: got %h required 55", r); end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_parity_error();
      test_overflow();
      test_timeout();
      test_irq();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
